// File: rtl/pio_pkg.sv
// Shared constants for the program-I/O blocks: instruction-memory geometry
// and the loader state encoding.
package pio_pkg;

    localparam int IMEM_ADDR_W = 5;
    localparam int INSTR_W     = 16;
    localparam int IMEM_DEPTH  = 32;

    // Loader states, kept as plain constants so older blocks can share them.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOW    = 3'd1;
    localparam logic [2:0] ST_HIGH   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_VERIFY = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: assembles 16-bit words from a low-byte-first
// byte stream and writes them to consecutive (wrapping) memory addresses,
// optionally reading each word back to check it landed correctly.
module instr_mem_loader
    import pio_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IMEM_ADDR_W-1:0] baseAddr,
    input  logic [IMEM_ADDR_W:0]   wordCount,
    input  logic                   verifyEn,
    input  logic [7:0]             inByte,
    input  logic                   inValid,
    output logic                   inReady,
    output logic [IMEM_ADDR_W-1:0] writeAddress,
    output logic [INSTR_W-1:0]     writeData,
    output logic                   writeEnable,
    output logic [IMEM_ADDR_W-1:0] readAddress,
    input  logic [INSTR_W-1:0]     readData,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [IMEM_ADDR_W:0]   wordsWritten
);

    logic [2:0]             state_reg;
    logic [IMEM_ADDR_W-1:0] base_reg;
    logic [IMEM_ADDR_W:0]   count_reg;
    logic                   verify_reg;
    logic [7:0]             lo_reg;
    logic [IMEM_ADDR_W-1:0] index_reg;
    logic [IMEM_ADDR_W-1:0] waddr_reg;
    logic [INSTR_W-1:0]     wdata_reg;
    logic [IMEM_ADDR_W:0]   wcnt_reg;
    logic                   error_reg;

    logic [IMEM_ADDR_W-1:0] target_addr;
    logic                   count_ok;
    logic                   last_word;

    // Address arithmetic wraps naturally in IMEM_ADDR_W bits.
    assign target_addr = base_reg + index_reg;
    assign count_ok    = (wordCount != '0) &&
                         (wordCount <= (IMEM_ADDR_W+1)'(IMEM_DEPTH));
    assign last_word   = (({1'b0, index_reg} + (IMEM_ADDR_W+1)'(1)) == count_reg);

    // Outputs decoded straight from state so they drop the instant reset hits.
    always_comb begin
        inReady      = (state_reg == ST_LOW) || (state_reg == ST_HIGH);
        writeEnable  = (state_reg == ST_WRITE);
        busy         = (state_reg != ST_IDLE);
        done         = (state_reg == ST_DONE);
        error        = error_reg;
        writeAddress = waddr_reg;
        writeData    = wdata_reg;
        readAddress  = target_addr;
        wordsWritten = wcnt_reg;
    end

    // Sequencer and datapath: byte capture, write strobe, read-back check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            base_reg   <= '0;
            count_reg  <= '0;
            verify_reg <= 1'b0;
            lo_reg     <= '0;
            index_reg  <= '0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
            wcnt_reg   <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (count_ok) begin
                            base_reg   <= baseAddr;
                            count_reg  <= wordCount;
                            verify_reg <= verifyEn;
                            error_reg  <= 1'b0;
                            wcnt_reg   <= '0;
                            index_reg  <= '0;
                            state_reg  <= ST_LOW;
                        end else begin
                            // Illegal length: flag it and finish without writing.
                            error_reg <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_LOW: begin
                    if (inValid) begin
                        lo_reg    <= inByte;
                        state_reg <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (inValid) begin
                        // Address/data registers only move here, so they hold
                        // the last written word between write strobes.
                        waddr_reg <= target_addr;
                        wdata_reg <= {inByte, lo_reg};
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wcnt_reg <= wcnt_reg + (IMEM_ADDR_W+1)'(1);
                    if (verify_reg) begin
                        state_reg <= ST_VERIFY;
                    end else if (last_word) begin
                        state_reg <= ST_DONE;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                        state_reg <= ST_LOW;
                    end
                end
                ST_VERIFY: begin
                    if (readData != wdata_reg) begin
                        error_reg <= 1'b1;
                    end
                    if (last_word) begin
                        state_reg <= ST_DONE;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                        state_reg <= ST_LOW;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a simple memory model that can
// corrupt one address on read-back.
module tb_instr_mem_loader;
    import pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  baseAddr = '0;
    logic [5:0]  wordCount = '0;
    logic        verifyEn = 1'b0;
    logic [7:0]  inByte = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [4:0]  writeAddress;
    logic [15:0] writeData;
    logic        writeEnable;
    logic [4:0]  readAddress;
    logic [15:0] readData;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  wordsWritten;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .baseAddr     (baseAddr),
        .wordCount    (wordCount),
        .verifyEn     (verifyEn),
        .inByte       (inByte),
        .inValid      (inValid),
        .inReady      (inReady),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .writeEnable  (writeEnable),
        .readAddress  (readAddress),
        .readData     (readData),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .wordsWritten (wordsWritten)
    );

    // Memory model with optional single-address read corruption.
    logic [15:0] mem [0:31];
    logic        corrupt_en = 1'b0;
    logic [4:0]  corrupt_addr = '0;

    always @(posedge clk) begin
        if (writeEnable) mem[writeAddress] <= writeData;
    end

    always_comb begin
        readData = mem[readAddress];
        if (corrupt_en && readAddress == corrupt_addr) readData = mem[readAddress] ^ 16'h0001;
    end

    // Write/done monitor.
    int          cyc = 0;
    int          last_we = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          done_base = 0;
    logic [4:0]  wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (writeEnable) begin
            wa_q.push_back(writeAddress);
            wd_q.push_back(writeData);
            wc_q.push_back(cyc);
            last_we <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [7:0] stim [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] q_addr(input int i);
        return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_data(input int i);
        return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic check_write(input string tag, input int i, input logic [4:0] a, input logic [15:0] d);
        check({tag, "_addr"}, q_addr(i), 32'(a));
        check({tag, "_data"}, q_data(i), 32'(d));
    endtask

    task automatic check_spacing(input string tag, input int gap);
        for (int i = 1; i < wc_q.size(); i++) begin
            check(tag, wc_q[i] - wc_q[i-1], gap);
        end
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] c, input logic v);
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_base = done_cnt;
        start     = 1'b1;
        baseAddr  = b;
        wordCount = c;
        verifyEn  = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int nbytes, input bit toggle, input bit mid_start);
        int idx = 0;
        int n   = 0;
        bit xfer;
        while (idx < nbytes && n < 500) begin
            inValid = toggle ? (n % 2 == 1) : 1'b1;
            inByte  = stim[idx];
            if (mid_start && (n % 5 == 2)) begin
                start     = 1'b1;
                baseAddr  = 5'd20;
                wordCount = 6'd1;
            end else begin
                start = 1'b0;
            end
            xfer = inValid && inReady;
            @(negedge clk);
            if (xfer) idx++;
            n++;
        end
        inValid = 1'b0;
        start   = 1'b0;
        check("bytes_taken", idx, nbytes);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == done_base && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt - done_base, 1);
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_inReady", inReady, 0);
        check("rst_we", writeEnable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_waddr", writeAddress, 0);
        check("rst_raddr", readAddress, 0);
        check("rst_wdata", writeData, 0);
        check("rst_count", wordsWritten, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic two-word load, no verify.
        stim[0] = 8'h34; stim[1] = 8'h12; stim[2] = 8'h78; stim[3] = 8'h56;
        do_start(5'd0, 6'd2, 1'b0);
        feed(4, 1'b0, 1'b0);
        wait_done();
        check("basic_nwr", wa_q.size(), 2);
        check_write("basic_w0", 0, 5'd0, 16'h1234);
        check_write("basic_w1", 1, 5'd1, 16'h5678);
        check_spacing("basic_gap", 3);
        check("basic_done_lat", done_cyc - last_we, 1);
        check("basic_count", wordsWritten, 2);
        check("basic_error", error, 0);
        check("basic_busy", busy, 0);
        check("basic_hold_data", writeData, 16'h5678);

        // Address wrap.
        for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
        do_start(5'd30, 6'd4, 1'b0);
        feed(8, 1'b0, 1'b0);
        wait_done();
        check("wrap_nwr", wa_q.size(), 4);
        check_write("wrap_w0", 0, 5'd30, 16'h0201);
        check_write("wrap_w1", 1, 5'd31, 16'h0403);
        check_write("wrap_w2", 2, 5'd0,  16'h0605);
        check_write("wrap_w3", 3, 5'd1,  16'h0807);
        check("wrap_count", wordsWritten, 4);

        // Verify catches a corrupted read-back; error is sticky.
        corrupt_en = 1'b1;
        corrupt_addr = 5'd5;
        stim[0] = 8'hAA; stim[1] = 8'hBB;
        do_start(5'd5, 6'd1, 1'b1);
        feed(2, 1'b0, 1'b0);
        wait_done();
        check_write("vbad_w0", 0, 5'd5, 16'hBBAA);
        check("vbad_done_lat", done_cyc - last_we, 2);
        check("vbad_error", error, 1);
        repeat (3) @(negedge clk);
        check("vbad_sticky", error, 1);
        corrupt_en = 1'b0;

        // Clean verify: next accepted start clears the error.
        stim[0] = 8'h01; stim[1] = 8'hC0; stim[2] = 8'h02; stim[3] = 8'hC0;
        do_start(5'd10, 6'd2, 1'b1);
        check("vok_err_clr", error, 0);
        feed(4, 1'b0, 1'b0);
        wait_done();
        check_write("vok_w1", 1, 5'd11, 16'hC002);
        check_spacing("vok_gap", 4);
        check("vok_done_lat", done_cyc - last_we, 2);
        check("vok_error", error, 0);
        check("vok_count", wordsWritten, 2);

        // Illegal lengths: 0 then 33.
        do_start(5'd0, 6'd0, 1'b0);
        check("cnt0_done", done, 1);
        check("cnt0_error", error, 1);
        check("cnt0_we", writeEnable, 0);
        @(negedge clk);
        check("cnt0_done_end", done, 0);
        check("cnt0_busy", busy, 0);
        check("cnt0_nwr", wa_q.size(), 0);
        stim[0] = 8'h00; stim[1] = 8'h00;
        do_start(5'd12, 6'd1, 1'b0);
        feed(2, 1'b0, 1'b0);
        wait_done();
        check("pre33_error", error, 0);
        do_start(5'd0, 6'd33, 1'b0);
        check("cnt33_done", done, 1);
        check("cnt33_error", error, 1);
        @(negedge clk);
        check("cnt33_done_end", done, 0);
        check("cnt33_nwr", wa_q.size(), 0);

        // Gappy stream with stray start pulses mid-load.
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
        stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
        do_start(5'd8, 6'd3, 1'b0);
        feed(6, 1'b1, 1'b1);
        wait_done();
        check("gap_nwr", wa_q.size(), 3);
        check_write("gap_w0", 0, 5'd8,  16'h2211);
        check_write("gap_w1", 1, 5'd9,  16'h4433);
        check_write("gap_w2", 2, 5'd10, 16'h6655);
        check("gap_count", wordsWritten, 3);

        // Reset while waiting for the high byte.
        do_start(5'd3, 6'd1, 1'b0);
        inValid = 1'b1;
        inByte  = 8'hEF;
        @(negedge clk);
        inValid = 1'b0;
        check("mid_inReady", inReady, 1);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_inReady", inReady, 0);
        check("arst_we", writeEnable, 0);
        check("arst_waddr", writeAddress, 0);
        check("arst_wdata", writeData, 0);
        check("arst_count", wordsWritten, 0);
        check("arst_raddr", readAddress, 0);
        @(negedge clk);
        check("arst_nwr", wa_q.size(), 0);
        reset = 1'b1;
        stim[0] = 8'hCD; stim[1] = 8'hAB;
        do_start(5'd3, 6'd1, 1'b0);
        feed(2, 1'b0, 1'b0);
        wait_done();
        check_write("post_w0", 0, 5'd3, 16'hABCD);
        check("post_count", wordsWritten, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
